// File: rtl/dsp_cascade_ctrl.sv
// 5-tap window sequencer for dsp_cascade: border-replicated pixel window,
// frame-synchronous coefficient bank and sync re-alignment of the result.
module dsp_cascade_ctrl #(
  parameter int CASC_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_pix,
  input  logic       in_de,
  input  logic       in_hs,
  input  logic       in_vs,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [2:0] cfg_data,
  output logic [7:0] pa,
  output logic [7:0] pb,
  output logic [7:0] pc,
  output logic [7:0] pd,
  output logic [7:0] pe,
  output logic       tap_valid,
  input  logic [7:0] casc_out,
  output logic [7:0] out_pix,
  output logic       out_de,
  output logic       out_hs,
  output logic       out_vs
);

  typedef enum logic [2:0] {
    SYNC_WAIT, IDLE, FILL, RUN, FLUSH
  } state_t;

  state_t     state;
  logic       two;
  logic [4:0] s0, s1, s2, s3;
  logic [4:0] smp, nxt;
  logic       act, load, shift, emit;
  logic       vs_q;
  logic [2:0] shadow [5];
  logic [2:0] active [5];
  logic [CASC_LAT:0]   tv_d;
  logic [CASC_LAT+3:0] hs_d, vs_d;
  logic       unused_pix;

  assign smp        = in_pix[7:3];
  assign unused_pix = ^in_pix[2:0];

  // Past the line end the newest tap repeats the last real pixel.
  always_comb begin
    act   = (state == FILL) || (state == RUN);
    load  = in_de && ((state == IDLE) || (state == FLUSH));
    shift = act || ((state == FLUSH) && !in_de);
    nxt   = (act && in_de) ? smp : s0;
    emit  = ((state == FILL) && two) || (state == RUN)
         || ((state == FLUSH) && !in_de);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SYNC_WAIT;
      two   <= 1'b0;
    end else begin
      unique case (state)
        SYNC_WAIT: if (!in_de) state <= IDLE;
        IDLE: begin
          if (in_de) state <= FILL;
          two <= 1'b0;
        end
        FILL: begin
          if (!in_de) state <= FLUSH;
          else if (two) state <= RUN;
          else two <= 1'b1;
        end
        RUN: if (!in_de) state <= FLUSH;
        FLUSH: begin
          state <= in_de ? FILL : IDLE;
          two   <= 1'b0;
        end
        default: state <= SYNC_WAIT;
      endcase
    end
  end

  // First pixel of a line fills the whole history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else if (load) begin
      s0 <= smp;
      s1 <= smp;
      s2 <= smp;
      s3 <= smp;
    end else if (shift) begin
      s3 <= s2;
      s2 <= s1;
      s1 <= s0;
      s0 <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap_valid <= 1'b0;
      pa <= '0;
      pb <= '0;
      pc <= '0;
      pd <= '0;
      pe <= '0;
    end else begin
      tap_valid <= emit;
      if (emit) begin
        pa <= {active[0], s3};
        pb <= {active[1], s2};
        pc <= {active[2], s1};
        pd <= {active[3], s0};
        pe <= {active[4], nxt};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        shadow[i] <= (i == 2) ? 3'd1 : 3'd0;
        active[i] <= (i == 2) ? 3'd1 : 3'd0;
      end
    end else begin
      vs_q <= in_vs;
      if (in_vs && !vs_q) active <= shadow;
      if (cfg_we && (cfg_addr < 3'd5)) shadow[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tv_d    <= '0;
      hs_d    <= '0;
      vs_d    <= '0;
      out_pix <= '0;
    end else begin
      tv_d    <= {tv_d[CASC_LAT-1:0], tap_valid};
      hs_d    <= {hs_d[CASC_LAT+2:0], in_hs};
      vs_d    <= {vs_d[CASC_LAT+2:0], in_vs};
      out_pix <= tv_d[CASC_LAT-1] ? casc_out : 8'd0;
    end
  end

  assign out_de = tv_d[CASC_LAT];
  assign out_hs = hs_d[CASC_LAT+3];
  assign out_vs = vs_d[CASC_LAT+3];

endmodule

// File: tb/tb_dsp_cascade_ctrl.sv
// Bench for dsp_cascade_ctrl: scheduled directed + random lines checked
// against a line-level window model, plus a mid-line reset scenario.
module tb_dsp_cascade_ctrl;

  localparam int L    = 4;
  localparam int MAXT = 1024;

  logic       clk;
  logic       rst;
  logic [7:0] in_pix;
  logic       in_de, in_hs, in_vs;
  logic       cfg_we;
  logic [2:0] cfg_addr, cfg_data;
  logic [7:0] pa, pb, pc, pd, pe;
  logic       tap_valid;
  logic [7:0] casc_out;
  logic [7:0] out_pix;
  logic       out_de, out_hs, out_vs;

  dsp_cascade_ctrl #(.CASC_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .in_pix(in_pix), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .pa(pa), .pb(pb), .pc(pc), .pd(pd), .pe(pe),
    .tap_valid(tap_valid), .casc_out(casc_out),
    .out_pix(out_pix), .out_de(out_de),
    .out_hs(out_hs), .out_vs(out_vs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub cascade: returns the centre sample L cycles later.
  logic [7:0] cd [L];
  initial for (int i = 0; i < L; i++) cd[i] = '0;
  always @(posedge clk) begin
    cd[0] <= pc;
    for (int i = 1; i < L; i++) cd[i] <= cd[i-1];
  end
  assign casc_out = {3'b000, cd[L-1][4:0]};

  bit         s_de [MAXT];
  bit         s_hs [MAXT];
  bit         s_vs [MAXT];
  bit         s_we [MAXT];
  logic [7:0] s_pix [MAXT];
  logic [2:0] s_addr [MAXT];
  logic [2:0] s_data [MAXT];
  bit         e_tv [MAXT];
  logic [7:0] e_tap [MAXT][5];
  logic [2:0] coef_at [MAXT][5];
  int T;
  int checks;
  int errors;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input bit de, input logic [7:0] pix, input bit vs,
                      input bit we, input logic [2:0] a, input logic [2:0] d);
    s_de[T]   = de;
    s_pix[T]  = pix;
    s_hs[T]   = 1'($urandom_range(0, 1));
    s_vs[T]   = vs;
    s_we[T]   = we;
    s_addr[T] = a;
    s_data[T] = d;
    T++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(0, 8'd0, 0, 0, 3'd0, 3'd0);
  endtask

  task automatic line_rand(input int n);
    for (int i = 0; i < n; i++)
      push(1, 8'($urandom_range(0, 255)), 0, 0, 3'd0, 3'd0);
  endtask

  // Line-level model: N pixels give N windows (N-1 before a 1-cycle gap),
  // window x appears 2 edges after pixel x with clamped neighbours.
  task automatic build_model();
    logic [2:0] sh [5];
    logic [2:0] ac [5];
    bit vp;
    int t, t0, n, g, w, idx;
    for (int i = 0; i < 5; i++) begin
      sh[i] = (i == 2) ? 3'd1 : 3'd0;
      ac[i] = sh[i];
    end
    vp = 0;
    for (int k = 0; k < T; k++) begin
      for (int i = 0; i < 5; i++) coef_at[k][i] = ac[i];
      if (s_vs[k] && !vp) ac = sh;
      vp = s_vs[k];
      if (s_we[k] && s_addr[k] < 3'd5) sh[s_addr[k]] = s_data[k];
      e_tv[k] = 0;
    end
    t = 0;
    while (t < T) begin
      if (s_de[t]) begin
        t0 = t;
        n  = 0;
        while (t < T && s_de[t]) begin n++; t++; end
        g = 0;
        while (t + g < T && !s_de[t+g]) g++;
        w = (g == 1) ? n - 1 : n;
        for (int x = 0; x < w; x++) begin
          e_tv[t0+x+2] = 1;
          for (int j = 0; j < 5; j++) begin
            idx = x + j - 2;
            if (idx < 0) idx = 0;
            if (idx > n - 1) idx = n - 1;
            e_tap[t0+x+2][j] = {coef_at[t0+x+2][j], s_pix[t0+idx][7:3]};
          end
        end
      end else begin
        t++;
      end
    end
  endtask

  task automatic check_edge(input int t);
    int tw, th;
    bit od;
    chk($sformatf("tap_valid@%0d", t), {7'd0, tap_valid}, {7'd0, e_tv[t]});
    if (e_tv[t]) begin
      chk($sformatf("pa@%0d", t), pa, e_tap[t][0]);
      chk($sformatf("pb@%0d", t), pb, e_tap[t][1]);
      chk($sformatf("pc@%0d", t), pc, e_tap[t][2]);
      chk($sformatf("pd@%0d", t), pd, e_tap[t][3]);
      chk($sformatf("pe@%0d", t), pe, e_tap[t][4]);
    end
    tw = t - L - 1;
    od = (tw >= 0) ? e_tv[tw] : 0;
    chk($sformatf("out_de@%0d", t), {7'd0, out_de}, {7'd0, od});
    chk($sformatf("out_pix@%0d", t), out_pix,
        od ? {3'b000, e_tap[tw][2][4:0]} : 8'd0);
    th = t - L - 3;
    chk($sformatf("out_hs@%0d", t), {7'd0, out_hs},
        {7'd0, (th >= 0) ? s_hs[th] : 1'b0});
    chk($sformatf("out_vs@%0d", t), {7'd0, out_vs},
        {7'd0, (th >= 0) ? s_vs[th] : 1'b0});
  endtask

  initial begin
    logic [7:0] rp [3];
    logic [7:0] fpa, fpc;
    int nwin, n, g;
    checks = 0;
    errors = 0;
    T = 0;
    rst = 1'b0;
    in_pix = '0; in_de = 0; in_hs = 0; in_vs = 0;
    cfg_we = 0; cfg_addr = '0; cfg_data = '0;

    idle(3);
    for (int i = 0; i < 8; i++) push(1, 8'(8 * i), 0, 0, 3'd0, 3'd0);
    idle(3);
    push(1, 8'hF8, 0, 0, 3'd0, 3'd0);
    idle(2);
    push(1, 8'(3 << 3), 0, 0, 3'd0, 3'd0);
    push(1, 8'(5 << 3), 0, 0, 3'd0, 3'd0);
    idle(2);
    push(0, 8'd0, 0, 1, 3'd0, 3'b010);
    push(0, 8'd0, 0, 1, 3'd6, 3'b111);
    idle(1);
    line_rand(5);
    idle(2);
    push(0, 8'd0, 1, 1, 3'd1, 3'b011);
    push(0, 8'd0, 1, 0, 3'd0, 3'd0);
    idle(1);
    line_rand(4);
    idle(2);
    push(0, 8'd0, 1, 0, 3'd0, 3'd0);
    idle(2);
    line_rand(3);
    idle(2);
    line_rand(6);
    idle(1);
    line_rand(6);
    idle(3);
    for (int k = 0; k < 25; k++) begin
      n = $urandom_range(1, 12);
      line_rand(n);
      g = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 4);
      for (int j = 0; j < g; j++)
        push(0, 8'd0, (j == 0) && ($urandom_range(0, 2) == 0),
             $urandom_range(0, 2) == 0,
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    idle(12);
    build_model();

    #22;
    chk("rst_tap_valid", {7'd0, tap_valid}, 8'd0);
    chk("rst_pa", pa, 8'd0);
    chk("rst_pc", pc, 8'd0);
    chk("rst_out_pix", out_pix, 8'd0);
    chk("rst_out_de", {7'd0, out_de}, 8'd0);
    chk("rst_out_hs", {7'd0, out_hs}, 8'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int t = 0; t < T; t++) begin
      @(negedge clk);
      in_de    = s_de[t];
      in_pix   = s_pix[t];
      in_hs    = s_hs[t];
      in_vs    = s_vs[t];
      cfg_we   = s_we[t];
      cfg_addr = s_addr[t];
      cfg_data = s_data[t];
      @(posedge clk);
      #1;
      check_edge(t);
    end

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cfg_we = 0;
      in_de  = 1;
      in_pix = 8'($urandom_range(0, 255));
      in_hs  = 1;
      in_vs  = 1;
    end
    @(posedge clk);
    #1;
    chk("pre_rst_tap_valid", {7'd0, tap_valid}, 8'd1);
    chk("pre_rst_out_de", {7'd0, out_de}, 8'd1);
    chk("pre_rst_out_hs", {7'd0, out_hs}, 8'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_pa", pa, 8'd0);
    chk("midrst_pb", pb, 8'd0);
    chk("midrst_pc", pc, 8'd0);
    chk("midrst_pd", pd, 8'd0);
    chk("midrst_pe", pe, 8'd0);
    chk("midrst_tap_valid", {7'd0, tap_valid}, 8'd0);
    chk("midrst_out_pix", out_pix, 8'd0);
    chk("midrst_out_de", {7'd0, out_de}, 8'd0);
    chk("midrst_out_hs", {7'd0, out_hs}, 8'd0);
    chk("midrst_out_vs", {7'd0, out_vs}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("syncwait_tv%0d", i), {7'd0, tap_valid}, 8'd0);
    end
    @(negedge clk);
    in_de = 0; in_hs = 0; in_vs = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) rp[i] = 8'($urandom_range(0, 255));
    nwin = 0;
    fpa = '0;
    fpc = '0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_de  = (i < 3);
      in_pix = (i < 3) ? rp[i] : 8'd0;
      @(posedge clk);
      #1;
      if (tap_valid) begin
        if (nwin == 0) begin
          fpa = pa;
          fpc = pc;
        end
        nwin++;
      end
    end
    chk("post_rst_windows", 8'(nwin), 8'd3);
    chk("post_rst_pa_default", fpa, {3'b000, rp[0][7:3]});
    chk("post_rst_pc_default", fpc, {3'b001, rp[0][7:3]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_cascade_ctrl.md
# dsp_cascade_ctrl

Sequencer for the 5-tap `dsp_cascade` in the HDMI convolution filter path. It builds a horizontal 5-pixel window from the incoming pixel stream, replicating pixels at line borders. It packs each tap as {coefficient select, sample} onto `pa`..`pe` and holds a frame-synchronous coefficient bank. It re-aligns the cascade result with delayed video syncs.

## Interface
- `CASC_LAT`, 4, `dsp_cascade` pipeline latency in cycles, from `pa`..`pe` registered to `p_out` valid; legal range 1..15.
- `clk`  in  1  pixel clock.
- `rst`  in  1  asynchronous, active-low reset.
- `in_pix`  in  8  input pixel; only [7:3] is used as the tap sample.
- `in_de`, `in_hs`, `in_vs`  in  1 each  input video timing.
- `cfg_we`  in  1  coefficient write strobe.
- `cfg_addr`  in  3  tap index 0..4 (a..e); 5..7 ignored.
- `cfg_data`  in  3  coefficient select.
- `pa`,`pb`,`pc`,`pd`,`pe`  out  8 each  taps x-2..x+2 as {coef[2:0], sample[4:0]}.
- `tap_valid`  out  1  window on `pa`..`pe` is valid.
- `casc_out`  in  8  `dsp_cascade` `p_out`.
- `out_pix`  out  8  filtered pixel; 0 when `out_de`=0.
- `out_de`, `out_hs`, `out_vs`  out  1 each  delayed timing aligned to `out_pix`.

## Operation
- FSM states:
  - SYNC_WAIT: entered on reset. Leaves to IDLE on the first cycle with `in_de`=0, so a line already in progress at reset release is ignored.
  - IDLE: moves to FILL on `in_de`=1.
  - FILL: first 2 pixels of a line. No window is emitted. Moves to RUN on the 3rd pixel.
  - RUN: one window per pixel. On `in_de` falling, moves to FLUSH.
  - FLUSH: emits the pending windows, min(2, pixels received), one per cycle, then returns to IDLE.
- Window contents: taps before the line start replicate pixel 0; taps past the line end replicate the last pixel. Every line of N≥1 pixels yields exactly N windows, e.g. N=1 gives one window with all samples = p0.
- Line gap:
  - Required minimum `in_de` low time is 2 cycles.
  - A 1-cycle gap drops the last window of the previous line (N-1 windows), and the new line starts in FILL.
  - `in_de`=1 on a FILL→RUN boundary cycle is counted normally.
- Coefficients:
  - `cfg_we` writes `cfg_data` into shadow[`cfg_addr`].
  - On the rising edge of `in_vs`, active ← shadow. A write in that same edge cycle lands in shadow only and is applied at the next frame.
  - Reset value of shadow and active: a,b,d,e = 3'b000, c = 3'b001.
- Output: `out_pix` ← `casc_out` when delayed tap_valid=1, else 0.
- Reset values: all outputs 0, `tap_valid`=0, window registers 0, all delay lines cleared.
- Reset mid-line: outputs go to 0 immediately. Active and shadow coefficients revert to defaults, and the FSM returns to SYNC_WAIT.

## Timing
- Pixel x sampled at edge k. Window x appears on `pa`..`pe` with `tap_valid`=1 after edge k+3: 2 cycles of lookahead plus 1 register.
- For contiguous lines, `tap_valid` equals `in_de` delayed by 3.
- `casc_out` is sampled CASC_LAT cycles after the window. `out_pix` is registered one cycle later.
- Total `in_pix`→`out_pix` latency is 4+CASC_LAT cycles.
- `out_hs` and `out_vs` are `in_hs`/`in_vs` delayed by 4+CASC_LAT.
- `out_de` is `tap_valid` delayed by CASC_LAT+1.
- Active coefficient change takes effect on the first window emitted after the `in_vs` rising edge.
- FSM and data path run back-to-back with no bubbles; throughput is 1 pixel/cycle.

## Test plan
- Reset-state check: assert `rst`=0 mid-stream with `in_de`=1. Required: all outputs 0 immediately. After release, nothing is emitted until `in_de` drops, and `pc`=8'b001_xxxxx coefficient default holds.
- Single line ramp: line of 8 pixels, in_pix=8·i, i=0..7. Required: 8 windows; window 0 samples {0,0,0,1,2}; window 7 samples {5,6,7,7,7}; `tap_valid` equals `in_de` delayed 3.
- Short lines: N=1 with pix=0xF8 gives 1 window, all samples 5'h1F. N=2 with samples 3,5 gives windows {3,3,3,5,5} and {3,3,5,5,5}.
- Coefficient update: write addr0=3'b010 mid-frame. Required: taps unchanged until the `in_vs` rise; then the first window has `pa`[7:5]=3'b010. A write with addr 6 has no effect. A write in the vs-edge cycle is applied only at the following frame.
- Alignment, CASC_LAT=4: a stub cascade returns `pc` delayed 4. Required: `out_pix`=`in_pix`&8'hF8 >> 3, zero-extended, exactly 8 cycles after input. `out_hs`/`out_vs`/`out_de` are delayed 8 and 0 outside `out_de`.
- 1-cycle de gap: two 6-pixel lines separated by 1 low cycle. Required: 5 windows for line 1 (the last is dropped) and 6 windows for line 2.
